// File: rtl/selector_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : selector_arbiter
// Brief    : Round-robin owner of a shared one-hot address selector; latches
//            the winner's address, waits a settle window, then grants.
// Revision : 1.0
// ============================================================================
module selector_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ADDR_W        = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
    input  logic [NUM_REQ-1:0]        rel,
    output logic [NUM_REQ-1:0]        grant,
    output logic [ADDR_W-1:0]         sel_addr,
    output logic                      sel_valid,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OWNED  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_ptr_rst  = IDX_W'(NUM_REQ - 1);
    localparam logic [7:0]       c_cnt_init = 8'(SETTLE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [ADDR_W-1:0]   sel_addr_q, sel_addr_d;

    logic                w_win_found;
    logic [IDX_W-1:0]    w_win_idx;
    logic [ADDR_W-1:0]   w_addr_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_addr_unpack
        assign w_addr_arr[k] = addr_in[k*ADDR_W +: ADDR_W];
    end

    // Search starts just after the last-served index, so it has lowest priority.
    always_comb begin
        int j;
        j           = 0;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = (int'(ptr_q) + i) % NUM_REQ;
            if (!w_win_found && req[IDX_W'(j)]) begin
                w_win_found = 1'b1;
                w_win_idx   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        sel_addr_d = sel_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (w_win_found) begin
                    owner_d    = w_win_idx;
                    sel_addr_d = w_addr_arr[w_win_idx];
                    cnt_d      = c_cnt_init;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!req[owner_q]) begin
                    ptr_d   = owner_q;
                    state_d = ST_IDLE;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    grant_d          = '0;
                    grant_d[owner_q] = 1'b1;
                    state_d          = ST_OWNED;
                end
            end
            ST_OWNED: begin
                // Release beats a simultaneous re-request from the same owner.
                if (rel[owner_q] || !req[owner_q]) begin
                    grant_d = '0;
                    ptr_d   = owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= c_ptr_rst;
            owner_q    <= '0;
            cnt_q      <= 8'd0;
            grant_q    <= '0;
            sel_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            sel_addr_q <= sel_addr_d;
        end
    end

    assign grant     = grant_q;
    assign sel_addr  = sel_addr_q;
    assign sel_valid = |grant_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_selector_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_selector_arbiter
// Brief    : Scoreboard bench for selector_arbiter; expected grants are queued
//            by the stimulus and checked by an independent monitor.
// Revision : 1.0
// ============================================================================
module tb_selector_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 16;
    localparam int SETTLE  = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*ADDR_W-1:0] addr_in = '0;
    logic [NUM_REQ-1:0]        rel = '0;
    logic [NUM_REQ-1:0]        grant;
    logic [ADDR_W-1:0]         sel_addr;
    logic                      sel_valid;
    logic                      busy;

    selector_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .ADDR_W       (ADDR_W),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr_in  (addr_in),
        .rel      (rel),
        .grant    (grant),
        .sel_addr (sel_addr),
        .sel_valid(sel_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_REQ-1:0] grant;
        logic [ADDR_W-1:0]  addr;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req_v);
        end
    endtask

    // Model of the downstream one-hot decoder line `idx`.
    function automatic logic dec(input logic [ADDR_W-1:0] a, input int idx);
        return (int'(a) == idx);
    endfunction

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   arb_cyc = 0;
    int   drop_cyc = 0;
    bit   gap_check = 0;
    logic busy_prev = 1'b0;
    logic valid_prev = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (busy && !busy_prev) begin
                arb_cyc = cyc;
                if (gap_check) check("idle_gap", cyc - drop_cyc, 1);
            end
            if (sel_valid && !valid_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", {28'd0, grant}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("grant", {28'd0, grant}, {28'd0, mon_e.grant});
                    check("sel_addr", {16'd0, sel_addr}, {16'd0, mon_e.addr});
                    check("settle_latency", cyc - arb_cyc, SETTLE);
                    check("decoded_hit", {31'd0, dec(sel_addr, int'(mon_e.addr))}, 32'd1);
                    if (mon_e.addr != 16'h0000)
                        check("decoded_below", {31'd0, dec(sel_addr, int'(mon_e.addr) - 1)}, 32'd0);
                    if (mon_e.addr != 16'hFFFF)
                        check("decoded_above", {31'd0, dec(sel_addr, int'(mon_e.addr) + 1)}, 32'd0);
                end
            end
            if (!sel_valid && valid_prev) drop_cyc = cyc;
        end
        busy_prev  = busy;
        valid_prev = sel_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req = '0; rel = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic expect_grant(input int k, input logic [ADDR_W-1:0] a);
        exp_t e;
        e.grant = 4'b0001 << k;
        e.addr  = a;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!sel_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!sel_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: no grant in 60 cycles, got sel_valid=0, required 1", name);
        end
    endtask

    task automatic release_owner(input int k, input bit drop_req);
        @(posedge clk);
        @(posedge clk); #1;
        rel = 4'b0001 << k;
        if (drop_req) req = req & ~(4'b0001 << k);
        @(posedge clk); #1;
        rel = '0;
        @(negedge clk);
        check("rel_grant", {28'd0, grant}, 32'd0);
        check("rel_valid", {31'd0, sel_valid}, 32'd0);
        check("rel_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic abort_then(input logic [3:0] next_req, input int exp_k);
        do_reset();
        addr_in[2*ADDR_W +: ADDR_W] = 16'h0BAD;
        req = 4'b0100;
        @(posedge clk);                 // E
        @(posedge clk);                 // E+1
        @(posedge clk); #1;             // E+2
        check("abort_busy_settle", {31'd0, busy}, 32'd1);
        req = 4'b0000;
        @(posedge clk);                 // E+3 samples the drop
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_grant", {28'd0, grant}, 32'd0);
        @(posedge clk); #1;
        addr_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        expect_grant(exp_k, addr_in[exp_k*ADDR_W +: ADDR_W]);
        req = next_req;
        wait_grant("abort_next");
        release_owner(exp_k, 1'b1);
        req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] a;
        int                k;

        // Reset, then a single requester.
        do_reset();
        @(negedge clk);
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_valid", {31'd0, sel_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sel_addr", {16'd0, sel_addr}, 32'd0);
        @(posedge clk); #1;
        addr_in[0 +: ADDR_W] = 16'h0001;
        expect_grant(0, 16'h0001);
        req = 4'b0001;
        wait_grant("single");
        release_owner(0, 1'b1);

        // Round robin with all four requesting.
        do_reset();
        addr_in = {16'hFFFF, 16'h8000, 16'h0000, 16'h0001};
        for (int i = 0; i < 5; i++) expect_grant(i % 4, addr_in[(i % 4)*ADDR_W +: ADDR_W]);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant("round_robin");
            gap_check = 1'b1;
            release_owner(i % 4, i == 4);
        end
        gap_check = 1'b0;
        req = '0;

        // Abort in SETTLE; follow-up arbitration shows where the pointer landed.
        abort_then(4'b0101, 0);
        abort_then(4'b1100, 3);

        // Address change while owned is ignored.
        do_reset();
        addr_in[1*ADDR_W +: ADDR_W] = 16'h1234;
        expect_grant(1, 16'h1234);
        req = 4'b0010;
        wait_grant("addr_immunity");
        #1 addr_in[1*ADDR_W +: ADDR_W] = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("addr_hold_owned", {16'd0, sel_addr}, 32'h1234);
        end
        release_owner(1, 1'b1);
        check("addr_hold_after_rel", {16'd0, sel_addr}, 32'h1234);

        // Reset while requester 2 owns the selector.
        do_reset();
        addr_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        expect_grant(2, 16'h3333);
        req = 4'b0100;
        wait_grant("pre_reset_owner");
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_grant", {28'd0, grant}, 32'd0);
        check("midrst_valid", {31'd0, sel_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_sel_addr", {16'd0, sel_addr}, 32'd0);
        #1 rst = 1'b0; req = '0;
        @(posedge clk); #1;
        expect_grant(0, 16'h1111);
        req = 4'b1111;
        wait_grant("post_reset_first");
        release_owner(0, 1'b1);
        req = '0;

        // Random addresses through random single requesters.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            k = int'($urandom_range(0, NUM_REQ - 1));
            a = 16'($urandom_range(0, 65535));
            addr_in = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            addr_in[k*ADDR_W +: ADDR_W] = a;
            expect_grant(k, a);
            req = 4'b0001 << k;
            wait_grant("random");
            release_owner(k, 1'b1);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
